// File: rtl/ser_pkg.sv
// ser_pkg: shared definitions for the serial line unit.
//   - Register offsets as seen on addr[3:2] of the I/O bus.
//   - Bit positions inside the receive/transmit control registers.
//   - Frame state enum used by both the receiver and the transmitter.
package ser_pkg;

  localparam logic [1:0] REG_RCV_CTRL = 2'd0;
  localparam logic [1:0] REG_RCV_DATA = 2'd1;
  localparam logic [1:0] REG_XMT_CTRL = 2'd2;
  localparam logic [1:0] REG_XMT_DATA = 2'd3;

  localparam int unsigned BIT_READY    = 0;
  localparam int unsigned BIT_IENABLE  = 1;
  localparam int unsigned BIT_OVERRUN  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/ser_rcv.sv
// ser_rcv: 8N1 receiver.
//   Two-flop synchronizer on the asynchronous line, start-bit validation at
//   half a bit time, eight data bits LSB first, stop-bit check.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   rxd_i        serial input (asynchronous, idle high)
//   byte_o       assembled byte, valid while strobe_o is high
//   strobe_o     one-cycle pulse on the edge that samples a good stop bit
//   frame_err_o  one-cycle pulse on the edge that samples a bad stop bit
module ser_rcv
  import ser_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       strobe_o,
  output logic       frame_err_o
);

  localparam logic [15:0] BIT_CNT  = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_CNT = 16'(BAUD_DIV / 2);

  logic        sync1_q, sync2_q;
  ser_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        expire;

  // Counter is loaded with N and the sample happens on the N-th edge after.
  assign expire = (cnt_q == 16'd1);
  assign byte_o = shift_q;

  // The synchronizer resets to the idle level so leaving reset is not
  // mistaken for a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // forming a true two-stage chain instead of collapsing into one flop.
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    strobe_o    = 1'b0;
    frame_err_o = 1'b0;
    if (state_q != ST_IDLE && !expire) cnt_d = cnt_q - 16'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          state_d = ST_START;
          cnt_d   = HALF_CNT;
        end
      end
      ST_START: begin
        if (expire) begin
          if (sync2_q) begin
            state_d = ST_IDLE;            // line went back high: a glitch
          end else begin
            state_d = ST_DATA;
            cnt_d   = BIT_CNT;
            bit_d   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (expire) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = BIT_CNT;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (expire) begin
          state_d     = ST_IDLE;
          strobe_o    = sync2_q;
          frame_err_o = ~sync2_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/ser.sv
// ser: byte-wide 8N1 serial line unit on the I/O bus.
//   Four 8-bit registers on addr: 0 rcv ctrl, 1 rcv data, 2 xmt ctrl,
//   3 xmt data. Every access takes two cycles (one wait state); side effects
//   happen on the edge that completes the access.
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   en, wr, addr   device select, write strobe, register select
//   data_in        write data
//   data_out       read data (0 when not selected)
//   wt             bus wait, high during the first access cycle
//   irq_r, irq_t   receive / transmit interrupt requests
//   rxd, txd       serial pins, idle high
module ser
  import ser_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       wt,
  output logic       irq_r,
  output logic       irq_t,
  input  logic       rxd,
  output logic       txd
);

  localparam logic [15:0] BIT_CNT = 16'(BAUD_DIV);

  logic        done_q;
  logic        rcv_ready_q, rcv_ovr_q, rcv_ie_q, xmt_ie_q;
  logic [7:0]  rcv_data_q;
  logic        complete, rd_rcv_data, xmt_start;
  logic [7:0]  rx_byte;
  logic        rx_strobe, frame_err_unused;

  ser_state_e  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        xmt_ready_q, xmt_ready_d;
  logic        tx_expire;

  // Framing errors only discard the byte; the pulse is not stored anywhere.
  ser_rcv #(.BAUD_DIV(BAUD_DIV)) u_rcv (
    .clk         (clk),
    .rst         (rst),
    .rxd_i       (rxd),
    .byte_o      (rx_byte),
    .strobe_o    (rx_strobe),
    .frame_err_o (frame_err_unused)
  );

  // Bus handshake: first cycle waits, second cycle completes.
  assign wt          = en & ~done_q;
  assign complete    = en & done_q;
  assign rd_rcv_data = complete & ~wr & (addr == REG_RCV_DATA);
  assign xmt_start   = complete & wr & (addr == REG_XMT_DATA) & xmt_ready_q;

  assign irq_r = rcv_ready_q & rcv_ie_q;
  assign irq_t = xmt_ready_q & xmt_ie_q;
  assign txd   = txd_q;

  always_comb begin
    data_out = 8'h00;
    if (en) begin
      unique case (addr)
        REG_RCV_CTRL: begin
          data_out[BIT_READY]   = rcv_ready_q;
          data_out[BIT_IENABLE] = rcv_ie_q;
          data_out[BIT_OVERRUN] = rcv_ovr_q;
        end
        REG_RCV_DATA: data_out = rcv_data_q;
        REG_XMT_CTRL: begin
          data_out[BIT_READY]   = xmt_ready_q;
          data_out[BIT_IENABLE] = xmt_ie_q;
        end
        REG_XMT_DATA: data_out = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      rcv_ready_q <= 1'b0;
      rcv_ovr_q   <= 1'b0;
      rcv_ie_q    <= 1'b0;
      xmt_ie_q    <= 1'b0;
      rcv_data_q  <= 8'h00;
    end else begin
      done_q <= en & ~done_q;
      // A byte arriving on the same edge as a data read wins; the read has
      // consumed the old byte, so no overrun is reported.
      if (rx_strobe) begin
        rcv_data_q  <= rx_byte;
        rcv_ready_q <= 1'b1;
        rcv_ovr_q   <= rcv_ready_q & ~rd_rcv_data;
      end else if (rd_rcv_data) begin
        rcv_ready_q <= 1'b0;
        rcv_ovr_q   <= 1'b0;
      end
      if (complete && wr && addr == REG_RCV_CTRL) rcv_ie_q <= data_in[BIT_IENABLE];
      if (complete && wr && addr == REG_XMT_CTRL) xmt_ie_q <= data_in[BIT_IENABLE];
    end
  end

  // Transmitter: txd is registered, so the start bit appears right after
  // the completing edge and each bit lasts exactly BAUD_DIV cycles.
  assign tx_expire = (tx_cnt_q == 16'd1);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    xmt_ready_d = xmt_ready_q;
    if (tx_state_q != ST_IDLE && !tx_expire) tx_cnt_d = tx_cnt_q - 16'd1;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (xmt_start) begin
          tx_state_d  = ST_START;
          tx_cnt_d    = BIT_CNT;
          tx_shift_d  = data_in;
          txd_d       = 1'b0;
          xmt_ready_d = 1'b0;
        end
      end
      ST_START: begin
        if (tx_expire) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = BIT_CNT;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end
      ST_DATA: begin
        if (tx_expire) begin
          tx_cnt_d = BIT_CNT;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (tx_expire) begin
          tx_state_d  = ST_IDLE;
          xmt_ready_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      txd_q       <= 1'b1;
      xmt_ready_q <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      xmt_ready_q <= xmt_ready_d;
    end
  end

endmodule

// File: tb/tb_ser.sv
// tb_ser: self-checking bench for ser with BAUD_DIV = 8.
// A frame-level model (timestamps of transmit starts, a queue of expected
// receive arrivals, register contents) predicts every output; a negedge
// process compares all outputs each cycle. Directed scenarios add
// hand-computed literal expectations, then a randomized phase runs bus
// traffic and receive frames concurrently.
module tb_ser;
  localparam int B = 8;

  logic       clk = 1'b0, rst = 1'b0;
  logic       en = 1'b0, wr = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       wt, irq_r, irq_t, txd;
  logic       rxd = 1'b1;

  ser #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .wt(wt), .irq_r(irq_r), .irq_t(irq_t),
    .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] b; } rx_ev_t;
  rx_ev_t     rxq[$];
  int         cyc;
  int         m_t0;
  logic       m_done, m_rcv_ready, m_ovr, m_rcv_ie, m_xmt_ie;
  logic [7:0] m_rcv_data, m_tx_byte;
  int         n_cmp = 0, n_err = 0;
  bit         cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit tx_busy(input int c);
    return (m_t0 >= 0) && (c - m_t0 < 10 * B);
  endfunction

  function automatic logic exp_txd();
    int k;
    if (!tx_busy(cyc)) return 1'b1;
    k = (cyc - m_t0) / B;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_tx_byte[k-1];
  endfunction

  function automatic logic [7:0] exp_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {5'b0, m_ovr, m_rcv_ie, m_rcv_ready};
      2'd1:    return m_rcv_data;
      2'd2:    return {6'b0, m_xmt_ie, ~tx_busy(cyc)};
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit rx_due_now();
    return (rxq.size() > 0) && (rxq[0].due == cyc + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0; m_done <= 1'b0; m_t0 <= -1;
      m_rcv_ready <= 1'b0; m_ovr <= 1'b0; m_rcv_ie <= 1'b0; m_xmt_ie <= 1'b0;
      m_rcv_data <= 8'h00; m_tx_byte <= 8'h00;
      rxq.delete();
    end else begin
      cyc    <= cyc + 1;
      m_done <= en & ~m_done;
      if (rx_due_now()) begin
        m_rcv_data  <= rxq[0].b;
        m_rcv_ready <= 1'b1;
        m_ovr       <= (en && m_done && !wr && addr == 2'd1) ? 1'b0 : m_rcv_ready;
        void'(rxq.pop_front());
      end else if (en && m_done && !wr && addr == 2'd1) begin
        m_rcv_ready <= 1'b0;
        m_ovr       <= 1'b0;
      end
      if (en && m_done && wr && addr == 2'd0) m_rcv_ie <= data_in[1];
      if (en && m_done && wr && addr == 2'd2) m_xmt_ie <= data_in[1];
      if (en && m_done && wr && addr == 2'd3 && !tx_busy(cyc)) begin
        m_t0      <= cyc + 1;
        m_tx_byte <= data_in;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("wt",       wt,       en & ~m_done);
      check("data_out", data_out, en ? exp_reg(addr) : 8'h00);
      check("irq_r",    irq_r,    m_rcv_ready & m_rcv_ie);
      check("irq_t",    irq_t,    ~tx_busy(cyc) & m_xmt_ie);
      check("txd",      txd,      exp_txd());
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d,
                     output logic [7:0] q);
    en = 1'b1; wr = w; addr = a; data_in = d;
    @(negedge clk); check("wt_first_cycle", wt, 1'b1);
    @(negedge clk); check("wt_second_cycle", wt, 1'b0);
    q = data_out;
    @(posedge clk); #1;
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] q);
    bus(1'b0, a, 8'h00, q);
  endtask

  task automatic wrt(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus(1'b1, a, d, q);
  endtask

  task automatic bus_abort(input logic w, input logic [1:0] a, input logic [7:0] d);
    en = 1'b1; wr = w; addr = a; data_in = d;
    tick(1);
    en = 1'b0; wr = 1'b0;
    tick(1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input int gap);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (stop) rxq.push_back('{cyc + 3 + B/2 + 9*B, b});
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      tick(B);
    end
    rxd = 1'b1;
    tick(gap);
  endtask

  task automatic rx_glitch();
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(B + 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] q;
    logic [9:0] pat;
    int         e;

    #2 rst = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_txd", txd, 1'b1);
    check("reset_irq_r", irq_r, 1'b0);
    check("reset_irq_t", irq_t, 1'b0);
    check("reset_wt", wt, 1'b0);
    check("reset_data_out", data_out, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    // Register reset values
    rd(2'd0, q); check("rcv_ctrl_reset", q, 8'h00);
    rd(2'd1, q); check("rcv_data_reset", q, 8'h00);
    rd(2'd2, q); check("xmt_ctrl_reset", q, 8'h01);
    rd(2'd3, q); check("xmt_data_reads0", q, 8'h00);

    // Transmit 0xA5 with interrupt enabled; busy write is dropped
    wrt(2'd2, 8'h02);
    check("irq_t_enabled", irq_t, 1'b1);
    wrt(2'd3, 8'hA5);
    e = cyc;
    check("irq_t_drop", irq_t, 1'b0);
    wrt(2'd3, 8'h3C);
    rd(2'd2, q); check("xmt_ctrl_busy", q, 8'h02);
    pat = 10'b1101001010;
    for (int k = 0; k < 10; k++) begin
      wait_cyc(e + k*B + B/2);
      check("tx_a5_bit", txd, pat[k]);
    end
    wait_cyc(e + 10*B - 1);
    check("irq_t_before_end", irq_t, 1'b0);
    wait_cyc(e + 10*B);
    check("irq_t_at_end", irq_t, 1'b1);
    wait_cyc(e + 10*B + 40);
    check("no_second_frame", txd, 1'b1);
    wrt(2'd2, 8'h00);

    // Receive 0x5A with interrupt enabled
    wrt(2'd0, 8'h02);
    rx_frame(8'h5A, 1'b1, 2);
    check("irq_r_set", irq_r, 1'b1);
    rd(2'd0, q); check("rcv_ctrl_ready", q, 8'h03);
    rd(2'd1, q); check("rcv_data_5a", q, 8'h5A);
    check("irq_r_clear", irq_r, 1'b0);

    // Back-to-back frames without reading: overrun
    rx_frame(8'h11, 1'b1, 0);
    rx_frame(8'h22, 1'b1, 2);
    rd(2'd0, q); check("rcv_ctrl_overrun", q, 8'h07);
    rd(2'd1, q); check("rcv_data_22", q, 8'h22);
    rd(2'd0, q); check("rcv_ctrl_cleared", q, 8'h02);

    // Framing error and a short glitch: nothing received
    rx_frame(8'h33, 1'b0, B);
    rd(2'd0, q); check("rcv_ctrl_frame_err", q, 8'h02);
    rx_glitch();
    tick(10);
    rd(2'd0, q); check("rcv_ctrl_glitch", q, 8'h02);

    // Randomized phase: bus traffic and receive frames in parallel
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int r;
          r = int'($urandom_range(0, 9));
          if (r == 0)      rx_glitch();
          else if (r == 1) rx_frame(8'($urandom), 1'b0, B);
          else             rx_frame(8'($urandom), 1'b1, (r < 5) ? 0 : int'($urandom_range(0, 2*B)));
        end
      end
      begin
        for (int i = 0; i < 600; i++) begin
          logic [7:0] rq;
          if ($urandom_range(0, 9) == 0)
            bus_abort(1'($urandom), 2'($urandom), 8'($urandom));
          else
            bus(1'($urandom), 2'($urandom), 8'($urandom), rq);
          tick(int'($urandom_range(0, 3)));
        end
      end
    join

    // Reset in the middle of a transmit frame
    tick(10*B + 20);
    wrt(2'd3, 8'h81);
    tick(30);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("txd_async_reset", txd, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);
    rd(2'd2, q); check("xmt_ready_after_reset", q, 8'h01);
    tick(20);
    check("txd_idle_after_reset", txd, 1'b1);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
